// File: rtl/instr_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Fetch sequencer for an 8-bit instruction memory with a combinational read
// port. It owns the program counter, drives the memory address and hands
// each fetched instruction, with the PC it came from, to decode through a
// one-entry valid/ready output register. It handles start, branch/jump
// redirect and detection of the HALT opcode.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   start          pulse that moves IDLE/HALT into RUN
//   redirect_valid branch/jump taken this cycle
//   redirect_addr  new PC target
//   mem_addr       instruction memory address (equals the PC)
//   mem_data       instruction read from mem_addr in the same cycle
//   out_valid      out_instr/out_pc hold an undelivered instruction
//   out_ready      decode accepts the held instruction this cycle
//   out_instr      fetched instruction
//   out_pc         address out_instr was fetched from
//   halted         high while in HALT
//   fetch_count    count of delivered instructions
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   defined   -> fetch_count counts transfers, wrapping at 16'hFFFF
//   undefined -> no counter register, fetch_count tied to 16'h0000
// ---------------------------------------------------------------------------
module instr_fetch_ctrl #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [DATA_W-1:0] HALT_OPCODE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_d;
  logic [DATA_W-1:0] instr_d;
  logic [ADDR_W-1:0] opc_d;
  logic              halted_d;
  logic              transfer;
  logic              slot_free;

  assign mem_addr  = pc_q;
  assign transfer  = out_valid && out_ready;
  assign slot_free = !out_valid || out_ready;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      halted    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      out_valid <= valid_d;
      out_instr <= instr_d;
      out_pc    <= opc_d;
      halted    <= halted_d;
    end
  end

  // Next-state and next-output logic. A redirect outranks everything but
  // reset: it flushes the output slot (even one being accepted this cycle)
  // and spends its edge loading the PC, so the target is fetched one edge
  // later.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = out_valid;
    instr_d = out_instr;
    opc_d   = out_pc;

    if (redirect_valid) begin
      pc_d    = redirect_addr;
      valid_d = 1'b0;
      if (state_q == IDLE) begin
        state_d = start ? RUN : IDLE;
      end else begin
        state_d = RUN;
      end
    end else begin
      if (transfer) begin
        valid_d = 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
          end
        end
        RUN: begin
          // The HALT opcode itself is delivered; only further fetches stop.
          if (slot_free) begin
            instr_d = mem_data;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
            if (mem_data == HALT_OPCODE) begin
              state_d = HALT;
            end
          end
        end
        HALT: begin
          if (start) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    halted_d = (state_d == HALT);
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] count_q;

  // Counts accepted instructions; a flushed slot is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'h0000;
    end else if (transfer && !redirect_valid) begin
      count_q <= count_q + 16'h0001;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 16'h0000;
`endif

endmodule
